output_signature_unit: RTL and testbench

Downstream capture stage for `RandomHardware`. It consumes the DUT's `io_out` bus every cycle during a programmed sample window and compresses it into a 32-bit MISR signature. It also accumulates a switching-activity count, the Hamming distance between consecutive samples, used as the power proxy. Results are held until software or bench acknowledges them, so fuzz runs compare one signature and one toggle count instead of 222-bit traces.

---
 rtl/output_signature_unit.sv | 138 +++++++++++++
 tb/tb_output_signature_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_signature_unit.sv
// rtl/output_signature_unit.sv - windowed MISR signature and toggle-count capture of a DUT output bus
// Define OUTSIG_TOGGLE_EN to build the toggle accumulator; otherwise io_toggles is tied to 0.
module output_signature_unit #(
  parameter int                   DATA_WIDTH = 222,
  parameter int                   SIG_WIDTH  = 32,
  parameter int                   CNT_WIDTH  = 16,
  parameter int                   TOG_WIDTH  = 32,
  parameter logic [SIG_WIDTH-1:0] POLY       = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED       = 32'hFFFFFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start,
  input  logic [CNT_WIDTH-1:0]  io_num_cycles,
  input  logic [DATA_WIDTH-1:0] io_data,
  input  logic                  io_ack,
  output logic                  io_busy,
  output logic                  io_done,
  output logic [SIG_WIDTH-1:0]  io_sig,
  output logic [TOG_WIDTH-1:0]  io_toggles
);

  localparam int NUM_CHUNKS = (DATA_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PAD_WIDTH  = NUM_CHUNKS * SIG_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   remaining_q;
  logic [SIG_WIDTH-1:0]   sig_q;
  logic [SIG_WIDTH-1:0]   sig_d;
  logic [SIG_WIDTH-1:0]   fold;
  logic [PAD_WIDTH-1:0]   data_pad;
  logic                   busy_q;
  logic                   done_q;

  // The bus is zero-padded up to a whole number of chunks before folding.
  always_comb begin
    data_pad                   = '0;
    data_pad[DATA_WIDTH-1:0]   = io_data;
    fold                       = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      fold = fold ^ data_pad[c*SIG_WIDTH +: SIG_WIDTH];
    end
    sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0} ^ (sig_q[SIG_WIDTH-1] ? POLY : '0) ^ fold;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      sig_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io_start) begin
            sig_q <= SEED;
            if (io_num_cycles != '0) begin
              remaining_q <= io_num_cycles;
              state_q     <= ST_RUN;
              busy_q      <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          sig_q       <= sig_d;
          remaining_q <= remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          // Ack takes priority over a simultaneous start; the start is dropped.
          if (io_ack) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io_busy = busy_q;
  assign io_done = done_q;
  assign io_sig  = sig_q;

`ifdef OUTSIG_TOGGLE_EN
  localparam int POP_W = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W = TOG_WIDTH + 1;

  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] diff;
  logic [POP_W-1:0]      pop;
  logic [SUM_W-1:0]      tog_sum;
  logic [TOG_WIDTH-1:0]  tog_q;
  logic [TOG_WIDTH-1:0]  tog_d;

  always_comb begin
    diff = io_data ^ prev_q;
    pop  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pop = pop + POP_W'(diff[i]);
    end
    tog_sum = {1'b0, tog_q} + SUM_W'(pop);
    tog_d   = tog_sum[TOG_WIDTH] ? '1 : tog_sum[TOG_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= '0;
      tog_q  <= '0;
    end else if (state_q == ST_IDLE && io_start) begin
      prev_q <= '0;
      tog_q  <= '0;
    end else if (state_q == ST_RUN) begin
      prev_q <= io_data;
      tog_q  <= tog_d;
    end
  end

  assign io_toggles = tog_q;
`else
  assign io_toggles = '0;
`endif

endmodule

// File: tb/tb_output_signature_unit.sv
// tb/tb_output_signature_unit.sv - self-checking bench for output_signature_unit
// Expected toggle counts follow OUTSIG_TOGGLE_EN of the build.
module tb_output_signature_unit;

  localparam int          DW   = 222;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;
`ifdef OUTSIG_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          io_start;
  logic [15:0]   io_num_cycles;
  logic [DW-1:0] io_data;
  logic          io_ack;
  logic          io_busy;
  logic          io_done;
  logic [31:0]   io_sig;
  logic [31:0]   io_toggles;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] win_q[$];

  output_signature_unit dut (
    .clock         (clock),
    .reset         (reset),
    .io_start      (io_start),
    .io_num_cycles (io_num_cycles),
    .io_data       (io_data),
    .io_ack        (io_ack),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_sig        (io_sig),
    .io_toggles    (io_toggles)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
    return w[DW-1:0];
  endfunction

  // Reference: each sample's 32-bit chunks are XORed together, then clocked into a CRC-style shifter.
  function automatic logic [31:0] exp_sig();
    logic [31:0]  s;
    logic [31:0]  f;
    logic [255:0] w;
    s = SEED;
    foreach (win_q[i]) begin
      w = 256'(win_q[i]);
      f = 32'h0;
      for (int c = 0; c < 8; c++) f = f ^ 32'(w >> (32 * c));
      s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_tog();
    longint        t;
    logic [DW-1:0] p;
    t = 0;
    p = '0;
    foreach (win_q[i]) begin
      t = t + $countones(win_q[i] ^ p);
      p = win_q[i];
    end
    if (t > 64'hFFFF_FFFF) t = 64'hFFFF_FFFF;
    return TOG_EN ? 32'(t) : 32'h0;
  endfunction

  // Starts a window of n samples from win_q; reports the edge (relative to start) where done appeared.
  task automatic drive_window(input int n, input int mid, output logic [31:0] s,
                              output logic [31:0] tg, output int done_at, output bit busy_ok);
    busy_ok       = 1'b1;
    done_at       = -1;
    io_num_cycles = 16'(n);
    io_start      = 1'b1;
    step();
    io_start = 1'b0;
    if (io_done) done_at = 0;
    else if (!io_busy) busy_ok = 1'b0;
    for (int i = 0; i < n + 4 && done_at < 0; i++) begin
      io_data = (i < n) ? win_q[i] : rand_data();
      if (i == mid) begin
        io_start      = 1'b1;
        io_num_cycles = 16'd1;
      end
      step();
      io_start = 1'b0;
      if (io_done) begin
        done_at = i + 1;
        if (io_busy) busy_ok = 1'b0;
      end else if (!io_busy) busy_ok = 1'b0;
    end
    s  = io_sig;
    tg = io_toggles;
  endtask

  task automatic do_ack();
    io_ack = 1'b1;
    step();
    io_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({io_busy, io_done, io_sig, io_toggles} !== 66'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b sig=%h tog=%h expected all zero",
               io_busy, io_done, io_sig, io_toggles);
    end
  endtask

  task automatic test_single_zero();
    logic [31:0] s, tg;
    int          d;
    bit          b;
    win_q = {};
    win_q.push_back('0);
    drive_window(1, -1, s, tg, d, b);
    checks++;
    if (s !== 32'hFB3EE249) begin
      errors++;
      $display("FAIL single_zero_sig: got %h expected %h", s, 32'hFB3EE249);
    end
    checks++;
    if (tg !== 32'h0 || d !== 1 || !b) begin
      errors++;
      $display("FAIL single_zero_timing: got tog=%0d done_at=%0d busy_ok=%0d expected 0 1 1", tg, d, b);
    end
    do_ack();
  endtask

  task automatic test_ones_hold();
    logic [31:0]   s, tg;
    logic [DW-1:0] ones;
    int            d;
    bit            b;
    ones  = '1;
    win_q = {};
    for (int i = 0; i < 3; i++) win_q.push_back(ones);
    drive_window(3, -1, s, tg, d, b);
    checks++;
    if (tg !== (TOG_EN ? 32'd222 : 32'd0)) begin
      errors++;
      $display("FAIL ones_hold_tog: got %0d expected %0d", tg, TOG_EN ? 222 : 0);
    end
    checks++;
    if (d !== 3 || !b || s !== exp_sig()) begin
      errors++;
      $display("FAIL ones_hold_done: got done_at=%0d busy_ok=%0d sig=%h expected 3 1 %h", d, b, s, exp_sig());
    end
    // Results are held in DONE until acknowledged.
    step();
    step();
    checks++;
    if (io_done !== 1'b1 || io_sig !== s) begin
      errors++;
      $display("FAIL done_hold: got done=%b sig=%h expected 1 %h", io_done, io_sig, s);
    end
    do_ack();
    checks++;
    if (io_done !== 1'b0 || io_busy !== 1'b0 || io_sig !== s) begin
      errors++;
      $display("FAIL ack_release: got done=%b busy=%b sig=%h expected 0 0 %h", io_done, io_busy, io_sig, s);
    end
  endtask

  task automatic test_alternating();
    logic [31:0]   s, tg;
    logic [DW-1:0] ones;
    int            d;
    bit            b;
    ones  = '1;
    win_q = {};
    win_q.push_back('0);
    win_q.push_back(ones);
    win_q.push_back('0);
    win_q.push_back(ones);
    drive_window(4, -1, s, tg, d, b);
    checks++;
    if (tg !== (TOG_EN ? 32'd666 : 32'd0) || s !== exp_sig() || d !== 4) begin
      errors++;
      $display("FAIL alternating: got tog=%0d sig=%h done_at=%0d expected %0d %h 4",
               tg, s, d, TOG_EN ? 666 : 0, exp_sig());
    end
    do_ack();
  endtask

  task automatic test_zero_length();
    logic [31:0] s, tg;
    int          d;
    bit          b;
    win_q = {};
    drive_window(0, -1, s, tg, d, b);
    checks++;
    if (d !== 0 || s !== SEED || tg !== 32'h0 || io_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_length: got done_at=%0d sig=%h tog=%0d busy=%b expected 0 %h 0 0", d, s, tg, io_busy, SEED);
    end
    io_start      = 1'b1;
    io_ack        = 1'b1;
    io_num_cycles = 16'd5;
    step();
    io_start = 1'b0;
    io_ack   = 1'b0;
    checks++;
    if (io_done !== 1'b0 || io_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ack_together: got done=%b busy=%b expected 0 0", io_done, io_busy);
    end
    step();
    checks++;
    if (io_done !== 1'b0 || io_busy !== 1'b0 || io_sig !== SEED) begin
      errors++;
      $display("FAIL dropped_start: got done=%b busy=%b sig=%h expected 0 0 %h", io_done, io_busy, io_sig, SEED);
    end
  endtask

  task automatic test_mid_start();
    logic [31:0] s, tg;
    int          d;
    bit          b;
    win_q = {};
    for (int i = 0; i < 6; i++) win_q.push_back(rand_data());
    drive_window(6, 2, s, tg, d, b);
    checks++;
    if (d !== 6 || !b || s !== exp_sig() || tg !== exp_tog()) begin
      errors++;
      $display("FAIL mid_start_ignored: got done_at=%0d busy_ok=%0d sig=%h tog=%0d expected 6 1 %h %0d",
               d, b, s, tg, exp_sig(), exp_tog());
    end
    do_ack();
  endtask

  task automatic test_reset_mid_window();
    logic [31:0] s, tg;
    int          d;
    bit          b;
    io_num_cycles = 16'd10;
    io_start      = 1'b1;
    step();
    io_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      io_data = rand_data();
      if (i == 4) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    checks++;
    if ({io_busy, io_done, io_sig, io_toggles} !== 66'h0) begin
      errors++;
      $display("FAIL reset_mid_window: got busy=%b done=%b sig=%h tog=%h expected all zero",
               io_busy, io_done, io_sig, io_toggles);
    end
    win_q = {};
    for (int i = 0; i < 10; i++) win_q.push_back(rand_data());
    drive_window(10, -1, s, tg, d, b);
    checks++;
    if (d !== 10 || !b || s !== exp_sig() || tg !== exp_tog()) begin
      errors++;
      $display("FAIL clean_after_reset: got done_at=%0d busy_ok=%0d sig=%h tog=%0d expected 10 1 %h %0d",
               d, b, s, tg, exp_sig(), exp_tog());
    end
    do_ack();
  endtask

  task automatic test_random_windows();
    logic [31:0] s, tg;
    int          d;
    int          n;
    bit          b;
    for (int w = 0; w < 10; w++) begin
      n     = $urandom_range(1, 24);
      win_q = {};
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) win_q.push_back(win_q[i-1]);
        else win_q.push_back(rand_data());
      end
      drive_window(n, -1, s, tg, d, b);
      checks++;
      if (d !== n || !b || s !== exp_sig() || tg !== exp_tog()) begin
        errors++;
        $display("FAIL random_window_%0d: got n=%0d done_at=%0d busy_ok=%0d sig=%h tog=%0d expected sig=%h tog=%0d",
                 w, n, d, b, s, tg, exp_sig(), exp_tog());
      end
      // The next start lands on the edge right after the ack (back-to-back).
      do_ack();
    end
  endtask

  initial begin
    reset         = 1'b1;
    io_start      = 1'b0;
    io_ack        = 1'b0;
    io_num_cycles = '0;
    io_data       = '0;
    test_reset();
    test_single_zero();
    test_ones_hold();
    test_alternating();
    test_zero_length();
    test_mid_start();
    test_reset_mid_window();
    test_random_windows();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
